// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with valid/ready handshake and 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  logic [31:0]      imm32;
  logic [5:0]       shamt;
  logic [XLEN-1:0]  sext;
  logic [XLEN-1:0]  new_imm;
  logic             new_ill;
  logic             or_v, sk_v, sk_ill;
  logic [XLEN-1:0]  sk_imm;
  logic [TAG_W-1:0] sk_tag;
  logic             accept, retire;
  // decode the selected format into a full-width immediate before it is stored
  always_comb begin
    imm32   = in_imm_src == 3'd0 ? {{20{in_instr[31]}}, in_instr[31:20]} :
              in_imm_src == 3'd1 ? {in_instr[31:12], 12'b0} :
              in_imm_src == 3'd2 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
              in_imm_src == 3'd3 ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                                   {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    shamt   = XLEN == 64 ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    sext    = XLEN'($signed(imm32));
    new_ill = in_imm_src == 3'd7;
    new_imm = in_imm_src == 3'd5 ? XLEN'(shamt) :
              in_imm_src == 3'd6 ? XLEN'(in_instr[19:15]) :
              new_ill            ? '0 : sext;
  end
  assign in_ready  = !sk_v;
  assign out_valid = or_v;
  assign accept    = in_valid && in_ready;
  assign retire    = or_v && out_ready;
  // output register fills directly when free, otherwise the skid slot absorbs one entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_v        <= 1'b0;
      sk_v        <= 1'b0;
      out_imm     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      sk_imm      <= '0;
      sk_tag      <= '0;
      sk_ill      <= 1'b0;
    end else if (accept && (!or_v || retire)) begin
      or_v        <= 1'b1;
      out_imm     <= new_imm;
      out_tag     <= in_tag;
      out_illegal <= new_ill;
    end else if (accept) begin
      sk_v   <= 1'b1;
      sk_imm <= new_imm;
      sk_tag <= in_tag;
      sk_ill <= new_ill;
    end else if (retire && sk_v) begin
      sk_v        <= 1'b0;
      out_imm     <= sk_imm;
      out_tag     <= sk_tag;
      out_illegal <= sk_ill;
    end else if (retire) begin
      or_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic [31:0] in_instr = 0;
  logic [2:0]  in_imm_src = 0;
  logic [31:0] in_tag = 0;
  logic        out_ready = 0;
  logic        ir32, ov32, ill32, ir64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          rst_seen = 0;
  typedef struct packed {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [31:0] tag;
    logic        ill;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] model(input logic [31:0] i, input logic [2:0] s, input int xlen);
    longint      si = longint'($signed(i));
    longint      sgn = si >>> 31;
    longint      hi = si >>> 25;
    logic [63:0] r;
    case (s)
      3'd0: r = si >>> 20;
      3'd1: begin r = si; r[11:0] = '0; end
      3'd2: r = (hi << 5) | ((i >> 7) & 31);
      3'd3: r = (sgn << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1);
      3'd4: r = (sgn << 20) | (((i >> 12) & 255) << 12) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1);
      3'd5: r = (i >> 20) & (xlen == 64 ? 63 : 31);
      3'd6: r = (i >> 15) & 31;
      default: r = 0;
    endcase
    return xlen == 32 ? (r & 64'hFFFF_FFFF) : r;
  endfunction

  // scoreboard: items accepted but not yet retired sit in q, in order
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk("rst_imm32", 64'(imm32), 0);
        chk("rst_imm64", imm64, 0);
        chk("rst_tag", 64'(tag32), 0);
        chk("rst_ill", 64'(ill32 | ill64), 0);
        rst_seen = 0;
      end
      chk("out_valid32", 64'(ov32), 64'(q.size() != 0));
      chk("out_valid64", 64'(ov64), 64'(q.size() != 0));
      chk("in_ready32", 64'(ir32), 64'(q.size() < 2));
      chk("in_ready64", 64'(ir64), 64'(q.size() < 2));
      if (ov32 && q.size() != 0) begin
        chk("imm32", 64'(imm32), 64'(q[0].i32));
        chk("imm64", imm64, q[0].i64);
        chk("tag", 64'(tag32), 64'(q[0].tag));
        chk("tag64", 64'(tag64), 64'(q[0].tag));
        chk("ill", 64'({ill32, ill64}), {62'b0, q[0].ill, q[0].ill});
      end
      if (ov32 && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && ir32)
        q.push_back('{model(in_instr, in_imm_src, 32), model(in_instr, in_imm_src, 64), in_tag, in_imm_src == 3'd7});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t);
    in_valid = 1;
    in_instr = i;
    in_imm_src = s;
    in_tag = t;
  endtask

  initial begin
    tick;
    tick;
    rst_n = 1;
    out_ready = 1;
    chk("post_rst_ready", 64'(ir32), 1);
    put(32'hFFF00093, 3'd0, 1);
    tick;
    chk("I_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("I_ill", 64'(ill32), 0);
    put(32'hFE000EE3, 3'd3, 2);
    tick;
    chk("B_imm32", 64'(imm32), 64'hFFFF_FFFC);
    put(32'hFF9FF06F, 3'd4, 3);
    tick;
    chk("J_imm32", 64'(imm32), 64'hFFFF_FFF8);
    chk("J_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    put(32'h80000037, 3'd1, 4);
    tick;
    chk("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("U_imm32", 64'(imm32), 64'h8000_0000);
    put(32'h03F01013, 3'd5, 5);
    tick;
    chk("shamt64", imm64, 64'h3F);
    chk("shamt32", 64'(imm32), 64'h1F);
    put($urandom, 3'd7, 6);
    tick;
    chk("illegal_imm", 64'(imm32), 0);
    chk("illegal_flag", 64'(ill32), 1);
    put(32'h0007D073, 3'd6, 7);
    tick;
    chk("zimm", 64'(imm32), 64'h0F);
    chk("zimm_ill", 64'(ill32), 0);
    in_valid = 0;
    tick;
    out_ready = 0;
    put(32'h00100093, 3'd0, 1);
    tick;
    put(32'h00200093, 3'd0, 2);
    tick;
    chk("bp_ready_full", 64'(ir32), 0);
    chk("bp_tag_held", 64'(tag32), 1);
    put(32'h00300093, 3'd0, 3);
    tick;
    chk("bp_tag_stable", 64'(tag32), 1);
    chk("bp_imm_stable", 64'(imm32), 1);
    out_ready = 1;
    tick;
    chk("bp_tag2", 64'(tag32), 2);
    tick;
    chk("bp_tag3", 64'(tag32), 3);
    in_valid = 0;
    tick;
    chk("bp_drained", 64'(ov32), 0);
    out_ready = 0;
    put(32'h00A00093, 3'd0, 10);
    tick;
    put(32'h00B00093, 3'd0, 11);
    tick;
    chk("mid_full", 64'(ir32), 0);
    rst_n = 0;
    put(32'h00C00093, 3'd0, 12);
    tick;
    rst_n = 1;
    in_valid = 0;
    chk("mid_rst_valid", 64'(ov32), 0);
    chk("mid_rst_ready", 64'(ir32), 1);
    chk("mid_rst_tag", 64'(tag32), 0);
    out_ready = 1;
    tick;
    tick;
    chk("no_stale", 64'(ov32 | ov64), 0);
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 299) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = $urandom;
      in_imm_src = 3'($urandom_range(0, 7));
      in_tag = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      tick;
    end
    in_valid = 0;
    out_ready = 1;
    tick;
    tick;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
